// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle between an operand source and the seq_alu block.
//
//   start    : request, sampled by the ALU only while it is not multiplying
//   S        : operation select (00 MUL, 01 CMP, 10 ADD, 11 SUB)
//   X, Y     : operands A and B
//   busy     : high while a multiply is iterating
//   done     : one-cycle pulse, result fields valid from this cycle on
//   F        : result
//   Cout     : carry / no-borrow / compare / multiply-overflow flag
//   Overflow : two's-complement overflow for ADD and SUB
//
// master : the side issuing requests (operand registers, testbench)
// slave  : the ALU itself
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [1:0]       S;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             Cout;
    logic             Overflow;

    modport master (
        output start, S, X, Y,
        input  busy, done, F, Cout, Overflow
    );

    modport slave (
        input  start, S, X, Y,
        output busy, done, F, Cout, Overflow
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered four-function ALU with a start/busy/done handshake. CMP, ADD and
// SUB complete in one cycle; MUL runs a WIDTH-step shift-add multiplier and
// reports whether the full product fits in WIDTH bits.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts a multiply in flight)
//   bus   : seq_alu_if.slave (start, S, X, Y in; busy, done, F, Cout,
//           Overflow out)
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 5,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_alu_if.slave    bus
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_f;
    logic                 r_cout;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH+1:0]     w_single;

    // Single-cycle ops. Returns {Overflow, Cout, F}; the (WIDTH+1)-bit sum
    // already carries Cout in its top bit.
    function automatic logic [WIDTH+1:0] single_op(
        input logic [1:0]       s,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] sum;
        logic           ovf;
        sum = '0;
        ovf = 1'b0;
        case (s)
            OP_ADD: begin
                sum = {1'b0, x} + {1'b0, y};
                ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry-out of X + ~Y + 1 is the "no borrow" flag.
                sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
                ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_CMP: begin
                sum = {(x > y), {WIDTH{1'b0}}};
            end
            default: begin
                sum = '0;
            end
        endcase
        return {ovf, sum};
    endfunction

    // Start is ignored (not queued) while multiplying.
    assign w_accept  = bus.start && (r_state != ST_MUL);
    assign w_last    = (r_state == ST_MUL) && (r_cnt == CW'(1));
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_single  = single_op(bus.S, bus.X, bus.Y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.S == OP_MUL) ? ST_MUL : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_f      <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            if (bus.S == OP_MUL) begin
                // Result registers are left alone so F holds during MUL.
                r_cnt    <= CW'(WIDTH);
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, bus.X};
                r_mplier <= bus.Y;
            end else begin
                {r_ovf, r_cout, r_f} <= w_single;
            end
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last) begin
                // Final partial product is folded in on this same edge.
                r_f    <= w_acc_nxt[WIDTH-1:0];
                r_cout <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_ovf  <= 1'b0;
            end
        end
    end

    assign bus.busy     = (r_state == ST_MUL);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.F        = r_f;
    assign bus.Cout     = r_cout;
    assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Scoreboard bench for seq_alu: the stimulus side pushes expected results,
// a negedge monitor pops and compares them whenever done is high.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] f;
        logic         c;
        logic         o;
        int           due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed view only for Overflow.
    function automatic exp_t model(input logic [1:0] s, input int a, input int b);
        exp_t e;
        int m, half, sa, sb, r;
        m    = 1 << W;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        e.f = '0; e.c = 1'b0; e.o = 1'b0; e.due = 0;
        case (s)
            2'b00: begin
                r   = a * b;
                e.f = W'(r % m);
                e.c = (r / m) != 0;
            end
            2'b01: e.c = (a > b);
            2'b10: begin
                r   = a + b;
                e.f = W'(r % m);
                e.c = (r >= m);
                e.o = ((sa + sb) < -half) || ((sa + sb) >= half);
            end
            default: begin
                r   = a - b;
                e.f = W'((r + m) % m);
                e.c = (a >= b);
                e.o = ((sa - sb) < -half) || ((sa - sb) >= half);
            end
        endcase
        return e;
    endfunction

    // Monitor: compare every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no pending op (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("F", bus.F, e.f);
                check("Cout", bus.Cout, e.c);
                check("Overflow", bus.Overflow, e.o);
                check("done_cycle", cyc, e.due);
            end
        end else if (bus.done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL done_unknown: done=%b (cycle %0d)", bus.done, cyc);
        end else if (q.size() > 0 && cyc > q[0].due) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, e.due);
        end
    end

    // Issue one op when the ALU can take it. Called on a negedge; returns on
    // the negedge of the op's DONE cycle (single-cycle ops) or, for MUL, on
    // the negedge of its DONE cycle after counting busy cycles.
    task automatic issue(input logic [1:0] s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_stuck: busy never fell before issue");
        end
        bus.start = 1'b1;
        bus.S     = s;
        bus.X     = x;
        bus.Y     = y;
        e     = model(s, x, y);
        e.due = cyc + 1 + ((s == 2'b00) ? W : 0);
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.S     = 2'($urandom);
        bus.X     = W'($urandom);
        bus.Y     = W'($urandom);
        if (s == 2'b00) begin
            n = 0;
            while (bus.busy === 1'b1 && n < 100) begin
                n++;
                if (poke && n == 2) begin
                    bus.start = 1'b1;
                    bus.S     = 2'b10;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
            end
            check("mul_busy_cycles", n, W);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.S     = 2'b00;
        bus.X     = '0;
        bus.Y     = '0;

        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_F", bus.F, 0);
        check("rst_Cout", bus.Cout, 0);
        check("rst_Overflow", bus.Overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        issue(2'b10, 5'b01111, 5'b00001, 0);
        issue(2'b10, 5'b11111, 5'b00001, 0);
        issue(2'b11, 5'b00011, 5'b00101, 0);
        issue(2'b11, 5'b10000, 5'b00001, 0);
        issue(2'b01, 5'b10000, 5'b01111, 0);
        issue(2'b01, 5'b00111, 5'b00111, 0);
        issue(2'b00, 5'b00110, 5'b00101, 1);
        issue(2'b00, 5'b11111, 5'b11111, 1);
        // ADD accepted in the DONE cycle of the MUL above.
        issue(2'b10, 5'b00101, 5'b00110, 0);
        @(negedge clk);

        // Leave a nonzero result in F, then abort a multiply in cycle 3.
        issue(2'b10, 5'b01111, 5'b00001, 0);
        bus.start = 1'b1;
        bus.S     = 2'b00;
        bus.X     = 5'b00111;
        bus.Y     = 5'b00011;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_F", bus.F, 0);
        check("abort_Cout", bus.Cout, 0);
        check("abort_Overflow", bus.Overflow, 0);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("abort_idle_busy", bus.busy, 0);
        issue(2'b00, 5'b00110, 5'b00101, 0);

        // Randomized traffic with occasional idle gaps and busy pokes.
        repeat (150) begin
            issue(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        repeat (W + 5) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
